rx_fir_sequencer: RTL

Control sequencer for a time-multiplexed receive FIR with built-in decimation. It accepts input samples over a valid/ready handshake and writes them into an external circular sample RAM. On every DECIM-th sample it walks one shared multiply-accumulate unit across all N taps, issuing sample-RAM read addresses, coefficient-ROM addresses and MAC strobes, then holds a result-valid handshake until downstream accepts. It replaces the fully parallel N-multiplier filter plus separate downsampler with a single MAC that is scheduled only for the outputs that survive decimation.

---
 rtl/rx_fir_pkg.sv | 31 +++
 rtl/rx_strobe_delay.sv | 38 +++
 rtl/rx_fir_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rx_fir_pkg.sv
// Shared types and helpers for the decimating receive FIR sequencer.
package rx_fir_pkg;

  localparam int unsigned N_DEFAULT          = 97;
  localparam int unsigned DATA_WIDTH_DEFAULT = 16;
  localparam int unsigned DECIM_DEFAULT      = 6;
  localparam int unsigned RD_LAT_DEFAULT     = 1;

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    WR,
    MAC,
    OUT
  } state_t;

  // MAC control strobes travelling through the read-latency delay line
  typedef struct packed {
    logic en;
    logic clr;
    logic last;
  } mac_strobe_t;

  // (a - b) mod n for a, b < n, without a divider
  function automatic int unsigned addr_mod_sub(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned n);
    return (a >= b) ? (a - b) : (a + n - b);
  endfunction

endpackage

// File: rtl/rx_strobe_delay.sv
// RD_LAT-deep shift register aligning MAC strobes with RAM/ROM read data.
module rx_strobe_delay
  import rx_fir_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  mac_strobe_t d,
  output mac_strobe_t q
);

  if (RD_LAT == 0) begin : g_bypass
    assign q = d;
  end else begin : g_pipe
    for (genvar i = 0; i < RD_LAT; i++) begin : g_stage
      mac_strobe_t prev;
      mac_strobe_t q_r;

      if (i == 0) begin : g_first
        assign prev = d;
      end else begin : g_next
        assign prev = g_stage[i-1].q_r;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          q_r <= '0;
        end else begin
          q_r <= prev;
        end
      end
    end

    assign q = g_stage[RD_LAT-1].q_r;
  end

endmodule

// File: rtl/rx_fir_sequencer.sv
// Control sequencer for a time-multiplexed decimating FIR: writes samples into a
// circular RAM and walks one shared MAC across all taps once per DECIM samples.
module rx_fir_sequencer
  import rx_fir_pkg::*;
#(
  parameter int unsigned N          = N_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned DECIM      = DECIM_DEFAULT,
  parameter int unsigned RD_LAT     = RD_LAT_DEFAULT,
  parameter int unsigned ADDR_WIDTH = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  buf_we,
  output logic [ADDR_WIDTH-1:0] buf_waddr,
  output logic [DATA_WIDTH-1:0] buf_wdata,
  output logic [ADDR_WIDTH-1:0] buf_raddr,
  output logic [ADDR_WIDTH-1:0] coef_addr,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic                  mac_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned MAC_CYCLES = N + RD_LAT;
  localparam int unsigned CNT_WIDTH  = $clog2(MAC_CYCLES + 1);
  localparam int unsigned PH_WIDTH   = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_t                  state, state_nx;
  logic [CNT_WIDTH-1:0]    cnt, cnt_nx;
  logic [ADDR_WIDTH-1:0]   wptr, wptr_nx;
  logic [ADDR_WIDTH-1:0]   newest, newest_nx;
  logic [ADDR_WIDTH-1:0]   k, k_nx;
  logic [PH_WIDTH-1:0]     phase, phase_nx;
  logic [DATA_WIDTH-1:0]   sample_q, sample_nx;
  mac_strobe_t             strobe_c;
  mac_strobe_t             strobe_d;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLR;
      cnt      <= '0;
      wptr     <= '0;
      newest   <= '0;
      k        <= '0;
      phase    <= '0;
      sample_q <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      wptr     <= wptr_nx;
      newest   <= newest_nx;
      k        <= k_nx;
      phase    <= phase_nx;
      sample_q <= sample_nx;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wptr_nx   = wptr;
    newest_nx = newest;
    k_nx      = k;
    phase_nx  = phase;
    sample_nx = sample_q;

    case (state)
      CLR: begin
        if (cnt == CNT_WIDTH'(N - 1)) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CNT_WIDTH'(1);
        end
      end

      IDLE: begin
        if (in_valid) begin
          sample_nx = in_data;
          state_nx  = WR;
        end
      end

      WR: begin
        newest_nx = wptr;
        wptr_nx   = (wptr == ADDR_WIDTH'(N - 1)) ? '0 : wptr + ADDR_WIDTH'(1);
        if (phase == PH_WIDTH'(DECIM - 1)) begin
          phase_nx = '0;
          k_nx     = '0;
          cnt_nx   = '0;
          state_nx = MAC;
        end else begin
          phase_nx = phase + PH_WIDTH'(1);
          state_nx = IDLE;
        end
      end

      MAC: begin
        // k stops at the last tap while the delayed strobes drain
        if (k != ADDR_WIDTH'(N - 1)) begin
          k_nx = k + ADDR_WIDTH'(1);
        end
        if (cnt == CNT_WIDTH'(MAC_CYCLES - 1)) begin
          cnt_nx   = '0;
          state_nx = OUT;
        end else begin
          cnt_nx = cnt + CNT_WIDTH'(1);
        end
      end

      OUT: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end

      default: state_nx = CLR;
    endcase
  end

  // Moore output decode from registered state and counters
  always_comb begin
    in_ready  = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = '0;
    buf_wdata = '0;
    buf_raddr = '0;
    coef_addr = '0;
    out_valid = 1'b0;
    strobe_c  = '0;
    busy      = (state != IDLE);

    case (state)
      CLR: begin
        buf_we    = 1'b1;
        buf_waddr = ADDR_WIDTH'(cnt);
      end
      IDLE: in_ready = 1'b1;
      WR: begin
        buf_we    = 1'b1;
        buf_waddr = wptr;
        buf_wdata = sample_q;
      end
      MAC: begin
        buf_raddr     = ADDR_WIDTH'(addr_mod_sub(32'(newest), 32'(k), N));
        coef_addr     = k;
        strobe_c.en   = (cnt < CNT_WIDTH'(N));
        strobe_c.clr  = (cnt == '0);
        strobe_c.last = (cnt == CNT_WIDTH'(N - 1));
      end
      OUT: out_valid = 1'b1;
      default: ;
    endcase
  end

  rx_strobe_delay #(
    .RD_LAT(RD_LAT)
  ) u_strobe_delay (
    .clk  (clk),
    .reset(reset),
    .d    (strobe_c),
    .q    (strobe_d)
  );

  assign mac_en   = strobe_d.en;
  assign mac_clr  = strobe_d.clr;
  assign mac_last = strobe_d.last;

endmodule
